// File: rtl/axi_reg_pkg.sv
// Shared types for the AXI register bank.
//   resp_t   : AXI response codes used on B and R.
//   wstate_t : write-path state (address/data collection, commit, response).
//   rstate_t : read-path state (accepting address, presenting data).
//   idx_width: register index width, never narrower than one bit.
package axi_reg_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    WS_IDLE,
    WS_HAVE_A,
    WS_HAVE_D,
    WS_COMMIT,
    WS_RESP
  } wstate_t;

  typedef enum logic {
    RS_IDLE,
    RS_DATA
  } rstate_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_reg_bank_if.sv
// AXI channel bundle between an interconnect (master) and the register bank
// (slave). Single-beat only: no burst length/size/type signals are carried.
//   AW : awid_i, awaddr_i, awvalid_i / awready_o
//   W  : wdata_i, wstrb_i, wlast_i, wvalid_i / wready_o
//   B  : bid_o, bresp_o, bvalid_o / bready_i
//   AR : arid_i, araddr_i, arvalid_i / arready_o
//   R  : rid_o, rdata_o, rresp_o, rlast_o, rvalid_o / rready_i
interface axi_reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wlast_i;
  logic              wvalid_i;
  logic              wready_o;
  logic [ID_W-1:0]   bid_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o;
  logic              bready_i;
  logic [ID_W-1:0]   arid_i;
  logic [ADDR_W-1:0] araddr_i;
  logic              arvalid_i;
  logic              arready_o;
  logic [ID_W-1:0]   rid_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              rvalid_o;
  logic              rready_i;

  modport master (
    output awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           bready_i, arid_i, araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bid_o, bresp_o, bvalid_o, arready_o,
           rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport slave (
    input  awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           bready_i, arid_i, araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bid_o, bresp_o, bvalid_o, arready_o,
           rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

endinterface

// File: rtl/axi_reg_decode.sv
// Byte address to register index decoder (combinational).
//   addr : AXI byte address
//   idx  : register index taken from the bits just above the byte offset
//   err  : index out of range, unaligned address, or stray upper bits set
module axi_reg_decode
  import axi_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REGS = 8,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = idx_width(N_REGS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              err
);

  localparam int LSB = $clog2(DATA_W / 8);
  localparam int HI  = LSB + IDX_W;

  // Everything above the index field must be zero; shifting keeps this
  // legal even when the index field reaches the top of the address.
  logic [ADDR_W-1:0] upper;

  assign upper = addr >> HI;
  assign idx   = addr[LSB +: IDX_W];
  assign err   = (32'(idx) >= 32'(N_REGS)) || (addr[LSB-1:0] != '0) || (upper != '0);

endmodule

// File: rtl/axi_reg_bank.sv
// AXI slave register bank, single-beat transactions only.
//   clk    : rising-edge clock
//   areset : synchronous active-low reset
//   bus    : AXI slave channels (AW/W/B/AR/R)
//   regs_o : every register flattened, register k at [k*DATA_W +: DATA_W]
// AW and W are collected independently in either order, committed in one
// cycle, then answered on B. Reads are answered one cycle after the AR
// handshake. The two paths share only the register file.
module axi_reg_bank
  import axi_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REGS = 8,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  axi_reg_bank_if.slave            bus,
  output logic [N_REGS*DATA_W-1:0] regs_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(N_REGS);

  wstate_t           wstate_reg;
  rstate_t           rstate_reg;
  logic              awready_reg, wready_reg, arready_reg;
  logic              bvalid_reg, rvalid_reg;
  logic [ID_W-1:0]   aw_id_reg, bid_reg, rid_reg;
  logic [IDX_W-1:0]  aw_idx_reg;
  logic              aw_err_reg;
  logic [DATA_W-1:0] w_data_reg, rdata_reg;
  logic [STRB_W-1:0] w_strb_reg;
  resp_t             bresp_reg, rresp_reg;

  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic              aw_err, ar_err;
  logic              aw_hs, w_hs, ar_hs, commit;
  logic [DATA_W-1:0] reg_view [N_REGS];
  logic              unused_wlast;

  axi_reg_decode #(.DATA_W(DATA_W), .N_REGS(N_REGS), .ADDR_W(ADDR_W), .IDX_W(IDX_W))
    u_aw_decode (.addr(bus.awaddr_i), .idx(aw_idx), .err(aw_err));
  axi_reg_decode #(.DATA_W(DATA_W), .N_REGS(N_REGS), .ADDR_W(ADDR_W), .IDX_W(IDX_W))
    u_ar_decode (.addr(bus.araddr_i), .idx(ar_idx), .err(ar_err));

  assign aw_hs  = bus.awvalid_i && awready_reg;
  assign w_hs   = bus.wvalid_i && wready_reg;
  assign ar_hs  = bus.arvalid_i && arready_reg;
  assign commit = (wstate_reg == WS_COMMIT) && !aw_err_reg;

  // Single-beat slave: the last-beat flag carries no information here.
  assign unused_wlast = bus.wlast_i;

  // Register file: one bank of flops per register so the whole set can be
  // exported in parallel on regs_o.
  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] value_reg;
      logic              hit;

      assign hit = commit && (aw_idx_reg == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (!areset) begin
          value_reg <= '0;
        end else if (hit) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_reg[b]) value_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
          end
        end
      end

      assign reg_view[gi]                 = value_reg;
      assign regs_o[gi*DATA_W +: DATA_W]  = value_reg;
    end
  endgenerate

  // Write path. Readies are registered; in the collection states a channel
  // stays ready until its own handshake, which also brings both readies up
  // on the first edge after reset.
  always_ff @(posedge clk) begin
    if (!areset) begin
      wstate_reg  <= WS_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bid_reg     <= '0;
      bresp_reg   <= RESP_OKAY;
      aw_id_reg   <= '0;
      aw_idx_reg  <= '0;
      aw_err_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else begin
      if (aw_hs) begin
        aw_id_reg  <= bus.awid_i;
        aw_idx_reg <= aw_idx;
        aw_err_reg <= aw_err;
      end
      if (w_hs) begin
        w_data_reg <= bus.wdata_i;
        w_strb_reg <= bus.wstrb_i;
      end
      unique case (wstate_reg)
        WS_IDLE: begin
          awready_reg <= !aw_hs;
          wready_reg  <= !w_hs;
          if (aw_hs && w_hs) wstate_reg <= WS_COMMIT;
          else if (aw_hs)    wstate_reg <= WS_HAVE_A;
          else if (w_hs)     wstate_reg <= WS_HAVE_D;
        end
        WS_HAVE_A: begin
          awready_reg <= 1'b0;
          wready_reg  <= !w_hs;
          if (w_hs) wstate_reg <= WS_COMMIT;
        end
        WS_HAVE_D: begin
          wready_reg  <= 1'b0;
          awready_reg <= !aw_hs;
          if (aw_hs) wstate_reg <= WS_COMMIT;
        end
        WS_COMMIT: begin
          bvalid_reg <= 1'b1;
          bid_reg    <= aw_id_reg;
          bresp_reg  <= aw_err_reg ? RESP_SLVERR : RESP_OKAY;
          wstate_reg <= WS_RESP;
        end
        WS_RESP: begin
          if (bus.bready_i) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            wstate_reg  <= WS_IDLE;
          end
        end
        default: wstate_reg <= WS_IDLE;
      endcase
    end
  end

  // Read path. Data is sampled at the AR handshake from the current
  // register contents, so a read racing a commit sees the old value.
  always_ff @(posedge clk) begin
    if (!areset) begin
      rstate_reg  <= RS_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rid_reg     <= '0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      case (rstate_reg)
        RS_IDLE: begin
          arready_reg <= !ar_hs;
          if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rid_reg    <= bus.arid_i;
            rdata_reg  <= ar_err ? '0 : reg_view[ar_idx];
            rresp_reg  <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rstate_reg <= RS_DATA;
          end
        end
        RS_DATA: begin
          if (bus.rready_i) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            rstate_reg  <= RS_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.awready_o = awready_reg;
  assign bus.wready_o  = wready_reg;
  assign bus.bvalid_o  = bvalid_reg;
  assign bus.bid_o     = bid_reg;
  assign bus.bresp_o   = bresp_reg;
  assign bus.arready_o = arready_reg;
  assign bus.rvalid_o  = rvalid_reg;
  assign bus.rid_o     = rid_reg;
  assign bus.rdata_o   = rdata_reg;
  assign bus.rresp_o   = rresp_reg;
  assign bus.rlast_o   = rvalid_reg;

endmodule

// File: tb/tb_axi_reg_bank.sv
// Self-checking bench for axi_reg_bank: directed scenarios plus a randomized
// write/readback run against an address-level register model.
module tb_axi_reg_bank;
  parameter int DATA_W = 32;
  parameter int N_REGS = 8;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic areset = 1'b0;
  logic [N_REGS*DATA_W-1:0] regs;

  axi_reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus_if ();

  axi_reg_bank #(.DATA_W(DATA_W), .N_REGS(N_REGS), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .areset(areset), .bus(bus_if), .regs_o(regs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model [N_REGS];

  // ---------------- reference model ----------------
  function automatic logic [ADDR_W-1:0] reg_addr(input int k);
    return ADDR_W'(k * STRB_W);
  endfunction

  function automatic bit addr_err(input logic [ADDR_W-1:0] a);
    longint unsigned au = 64'(a);
    return (au % STRB_W != 0) || (au / STRB_W >= N_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] data,
                                               input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r = old;
    for (int b = 0; b < STRB_W; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [N_REGS*DATA_W-1:0] model_flat();
    logic [N_REGS*DATA_W-1:0] f;
    for (int k = 0; k < N_REGS; k++) f[k*DATA_W +: DATA_W] = model[k];
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [63:0] w = {$urandom(), $urandom()};
    return DATA_W'(w);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_REGS; k++) model[k] = '0;
  endtask

  // ---------------- bus drivers ----------------
  task automatic drive_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int dly, output bit ok);
    ok = 1'b0;
    repeat (dly) @(posedge clk);
    #1;
    bus_if.awid_i = id; bus_if.awaddr_i = addr; bus_if.awvalid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = bus_if.awready_o;
      @(posedge clk); #1;
    end
    bus_if.awvalid_i = 1'b0;
  endtask

  task automatic drive_w(input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                         input int dly, output bit ok);
    ok = 1'b0;
    repeat (dly) @(posedge clk);
    #1;
    bus_if.wdata_i = data; bus_if.wstrb_i = strb; bus_if.wlast_i = 1'b1; bus_if.wvalid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = bus_if.wready_o;
      @(posedge clk); #1;
    end
    bus_if.wvalid_i = 1'b0;
  endtask

  task automatic drive_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          output bit ok);
    ok = 1'b0;
    #1;
    bus_if.arid_i = id; bus_if.araddr_i = addr; bus_if.arvalid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = bus_if.arready_o;
      @(posedge clk); #1;
    end
    bus_if.arvalid_i = 1'b0;
  endtask

  task automatic write_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                           input int dly_a, input int dly_w, input int dly_b,
                           output logic [ID_W-1:0] got_id, output logic [1:0] got_resp,
                           output bit ok);
    bit oka, okw, okb;
    fork
      drive_aw(id, addr, dly_a, oka);
      drive_w(data, strb, dly_w, okw);
    join
    okb = 1'b0; got_id = '0; got_resp = 2'b11;
    if (oka && okw) begin
      for (int i = 0; i < 50 && !okb; i++) begin
        @(negedge clk);
        if (bus_if.bvalid_o) begin
          okb = 1'b1; got_id = bus_if.bid_o; got_resp = bus_if.bresp_o;
        end
      end
      if (okb) begin
        repeat (dly_b) @(negedge clk);
        bus_if.bready_i = 1'b1;
        @(posedge clk); #1;
        bus_if.bready_i = 1'b0;
      end
    end
    ok = oka && okw && okb;
    $display("WR id=%0d addr=%h data=%h strb=%b -> bid=%0d bresp=%b done=%0d",
             id, addr, data, strb, got_id, got_resp, ok);
  endtask

  task automatic read_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int dly_r, output logic [ID_W-1:0] got_id,
                          output logic [DATA_W-1:0] got_data, output logic [1:0] got_resp,
                          output logic got_last, output bit ok);
    bit oka;
    drive_ar(id, addr, oka);
    ok = 1'b0; got_id = '0; got_data = '0; got_resp = 2'b11; got_last = 1'b0;
    if (oka) begin
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (bus_if.rvalid_o) begin
          ok = 1'b1; got_id = bus_if.rid_o; got_data = bus_if.rdata_o;
          got_resp = bus_if.rresp_o; got_last = bus_if.rlast_o;
        end
      end
      if (ok) begin
        repeat (dly_r) @(negedge clk);
        bus_if.rready_i = 1'b1;
        @(posedge clk); #1;
        bus_if.rready_i = 1'b0;
      end
    end
    $display("RD id=%0d addr=%h -> rid=%0d rdata=%h rresp=%b rlast=%0d done=%0d",
             id, addr, got_id, got_data, got_resp, got_last, ok);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    areset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_if.awready_o, bus_if.wready_o, bus_if.arready_o, bus_if.bvalid_o, bus_if.rvalid_o} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 00000",
        {bus_if.awready_o, bus_if.wready_o, bus_if.arready_o, bus_if.bvalid_o, bus_if.rvalid_o});
    end
    checks++;
    if ({bus_if.bid_o, bus_if.bresp_o, bus_if.rid_o, bus_if.rresp_o, bus_if.rdata_o} !== '0) begin
      errors++; $display("FAIL reset_resp: bid=%h bresp=%b rid=%h rresp=%b rdata=%h want all 0",
        bus_if.bid_o, bus_if.bresp_o, bus_if.rid_o, bus_if.rresp_o, bus_if.rdata_o);
    end
    checks++;
    if (regs !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs); end
    @(posedge clk); #1 areset = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if ({bus_if.awready_o, bus_if.wready_o, bus_if.arready_o} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge: got %b want 000",
        {bus_if.awready_o, bus_if.wready_o, bus_if.arready_o});
    end
    @(negedge clk);
    checks++;
    if ({bus_if.awready_o, bus_if.wready_o, bus_if.arready_o} !== 3'b111) begin
      errors++; $display("FAIL ready_after_release: got %b want 111",
        {bus_if.awready_o, bus_if.wready_o, bus_if.arready_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] d = DATA_W'(32'hDEADBEEF);
    bus_if.awid_i = 4'd3; bus_if.awaddr_i = reg_addr(2); bus_if.awvalid_i = 1'b1;
    bus_if.wdata_i = d; bus_if.wstrb_i = '1; bus_if.wlast_i = 1'b1; bus_if.wvalid_i = 1'b1;
    @(posedge clk); #1;
    bus_if.awvalid_i = 1'b0; bus_if.wvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.bvalid_o !== 1'b0) begin errors++; $display("FAIL b_early: bvalid=%b want 0", bus_if.bvalid_o); end
    @(negedge clk);
    checks++;
    if ({bus_if.bvalid_o, bus_if.bid_o, bus_if.bresp_o} !== {1'b1, 4'd3, 2'b00}) begin
      errors++; $display("FAIL b_same_cycle: bvalid=%b bid=%0d bresp=%b want 1/3/00",
        bus_if.bvalid_o, bus_if.bid_o, bus_if.bresp_o);
    end
    model[2] = merge(model[2], d, '1);
    checks++;
    if (regs[2*DATA_W +: DATA_W] !== DATA_W'(32'hDEADBEEF)) begin
      errors++; $display("FAIL reg2_commit: got %h want %h", regs[2*DATA_W +: DATA_W], DATA_W'(32'hDEADBEEF));
    end
    $display("WR id=3 addr=%h data=%h strb=all (same-cycle AW/W)", reg_addr(2), d);
    bus_if.bready_i = 1'b1;
    @(posedge clk); #1 bus_if.bready_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.bvalid_o, bus_if.awready_o, bus_if.wready_o} !== 3'b011) begin
      errors++; $display("FAIL b_release: {bvalid,awready,wready}=%b want 011",
        {bus_if.bvalid_o, bus_if.awready_o, bus_if.wready_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w_first();
    logic [DATA_W-1:0] d = DATA_W'(32'h12345678);
    logic [STRB_W-1:0] s = STRB_W'(4'b0101);
    bit ok, got;
    bus_if.wdata_i = d; bus_if.wstrb_i = s; bus_if.wlast_i = 1'b1; bus_if.wvalid_i = 1'b1;
    @(posedge clk); #1 bus_if.wvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.awready_o, bus_if.wready_o} !== 2'b10) begin
      errors++; $display("FAIL have_d_readies: {awready,wready}=%b want 10", {bus_if.awready_o, bus_if.wready_o});
    end
    drive_aw(4'd6, reg_addr(1), 2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL aw_after_w: handshake=%0d want 1", ok); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus_if.bvalid_o; end
    model[1] = merge(model[1], d, s);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus_if.bvalid_o, bus_if.bid_o, bus_if.bresp_o} !== {1'b1, 4'd6, 2'b00}) begin
        errors++; $display("FAIL b_hold[%0d]: bvalid=%b bid=%0d bresp=%b want 1/6/00",
          i, bus_if.bvalid_o, bus_if.bid_o, bus_if.bresp_o);
      end
      @(negedge clk);
    end
    checks++;
    if (regs[1*DATA_W +: DATA_W] !== DATA_W'(32'h00340078)) begin
      errors++; $display("FAIL reg1_strobe: got %h want %h", regs[1*DATA_W +: DATA_W], DATA_W'(32'h00340078));
    end
    $display("WR id=6 addr=%h data=%h strb=%b (W first)", reg_addr(1), d, s);
    bus_if.bready_i = 1'b1;
    @(posedge clk); #1 bus_if.bready_i = 1'b0;
  endtask

  task automatic test_errors();
    logic [ADDR_W-1:0] bad [4];
    logic [ID_W-1:0] gid; logic [1:0] gresp; logic [DATA_W-1:0] gdata; logic glast; bit ok;
    bad[0] = reg_addr(N_REGS); bad[1] = ADDR_W'(2); bad[2] = 32'h8000_0000; bad[3] = reg_addr(N_REGS-1) + 1;
    for (int i = 0; i < 4; i++) begin
      write_txn(ID_W'(i + 8), bad[i], rand_data(), '1, 0, 1, 0, gid, gresp, ok);
      checks++;
      if (!ok || gresp !== 2'b10 || gid !== ID_W'(i + 8)) begin
        errors++; $display("FAIL wr_err[%0d]: done=%0d bid=%0d bresp=%b want 1/%0d/10", i, ok, gid, gresp, i + 8);
      end
      checks++;
      if (regs !== model_flat()) begin
        errors++; $display("FAIL regs_untouched[%0d]: got %h want %h", i, regs, model_flat());
      end
    end
    for (int i = 0; i < 2; i++) begin
      read_txn(ID_W'(i + 1), bad[i], 0, gid, gdata, gresp, glast, ok);
      checks++;
      if (!ok || gdata !== '0 || gresp !== 2'b10 || gid !== ID_W'(i + 1)) begin
        errors++; $display("FAIL rd_err[%0d]: done=%0d rid=%0d rdata=%h rresp=%b want 1/%0d/0/10",
          i, ok, gid, gdata, gresp, i + 1);
      end
    end
  endtask

  task automatic test_read_hold();
    logic [DATA_W-1:0] old, nv;
    logic [ID_W-1:0] gid; logic [1:0] gresp; logic [DATA_W-1:0] gdata; logic glast; bit ok;
    drive_ar(4'd5, reg_addr(2), ok);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, bus_if.rvalid_o, bus_if.rlast_o, bus_if.rid_o, bus_if.rresp_o} !== {3'b111, 4'd5, 2'b00}) begin
        errors++; $display("FAIL r_hold[%0d]: ar=%0d rvalid=%b rlast=%b rid=%0d rresp=%b want 1/1/1/5/00",
          i, ok, bus_if.rvalid_o, bus_if.rlast_o, bus_if.rid_o, bus_if.rresp_o);
      end
      checks++;
      if (bus_if.rdata_o !== model[2]) begin
        errors++; $display("FAIL r_hold_data[%0d]: got %h want %h", i, bus_if.rdata_o, model[2]);
      end
    end
    bus_if.rready_i = 1'b1;
    @(posedge clk); #1 bus_if.rready_i = 1'b0;
    $display("RD id=5 addr=%h held 4 cycles", reg_addr(2));
    // read racing a commit to the same register
    old = model[2]; nv = DATA_W'(1);
    bus_if.awid_i = 4'd1; bus_if.awaddr_i = reg_addr(2); bus_if.awvalid_i = 1'b1;
    bus_if.wdata_i = nv; bus_if.wstrb_i = '1; bus_if.wvalid_i = 1'b1;
    @(posedge clk); #1;
    bus_if.awvalid_i = 1'b0; bus_if.wvalid_i = 1'b0;
    bus_if.arid_i = 4'd7; bus_if.araddr_i = reg_addr(2); bus_if.arvalid_i = 1'b1;
    @(posedge clk); #1 bus_if.arvalid_i = 1'b0;
    @(negedge clk);
    model[2] = merge(model[2], nv, '1);
    checks++;
    if ({bus_if.rvalid_o, bus_if.rid_o} !== {1'b1, 4'd7} || bus_if.rdata_o !== old) begin
      errors++; $display("FAIL read_vs_commit: rvalid=%b rid=%0d rdata=%h want 1/7/%h",
        bus_if.rvalid_o, bus_if.rid_o, bus_if.rdata_o, old);
    end
    checks++;
    if (bus_if.bvalid_o !== 1'b1 || regs !== model_flat()) begin
      errors++; $display("FAIL commit_vs_read: bvalid=%b regs=%h want 1/%h", bus_if.bvalid_o, regs, model_flat());
    end
    $display("RD id=7 addr=%h during commit -> rdata=%h", reg_addr(2), bus_if.rdata_o);
    bus_if.rready_i = 1'b1; bus_if.bready_i = 1'b1;
    @(posedge clk); #1;
    bus_if.rready_i = 1'b0; bus_if.bready_i = 1'b0;
    read_txn(4'd2, reg_addr(2), 1, gid, gdata, gresp, glast, ok);
    checks++;
    if (!ok || gdata !== model[2] || gresp !== 2'b00) begin
      errors++; $display("FAIL readback_new: done=%0d rdata=%h rresp=%b want 1/%h/00", ok, gdata, gresp, model[2]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen_b;
    drive_aw(4'd2, reg_addr(3), 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL aw_before_reset: handshake=%0d want 1", ok); end
    areset = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (regs !== '0 || {bus_if.awready_o, bus_if.wready_o, bus_if.arready_o} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_state: regs=%h readies=%b want 0/000",
        regs, {bus_if.awready_o, bus_if.wready_o, bus_if.arready_o});
    end
    @(negedge clk);
    checks++;
    if ({bus_if.awready_o, bus_if.wready_o, bus_if.arready_o} !== 3'b111) begin
      errors++; $display("FAIL mid_reset_ready: got %b want 111", {bus_if.awready_o, bus_if.wready_o, bus_if.arready_o});
    end
    seen_b = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen_b = seen_b | bus_if.bvalid_o; end
    checks++;
    if (seen_b !== 1'b0) begin errors++; $display("FAIL abandoned_b: bvalid seen=%b want 0", seen_b); end
    $display("RST during AW-only write, no B expected");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [ID_W-1:0] id, gid; logic [1:0] gresp, eresp;
    logic [DATA_W-1:0] d, gdata, edata; logic [STRB_W-1:0] s; logic glast;
    logic [ADDR_W-1:0] a; bit ok, err;
    for (int i = 0; i < 16; i++) begin
      a = reg_addr($urandom_range(0, N_REGS));
      if ($urandom_range(0, 7) == 0) a = a + 1;
      d = rand_data(); s = STRB_W'($urandom());
      if (i == 3) s = '0;
      id = ID_W'($urandom());
      err = addr_err(a);
      eresp = err ? 2'b10 : 2'b00;
      write_txn(id, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), gid, gresp, ok);
      if (!err) model[a / STRB_W] = merge(model[a / STRB_W], d, s);
      checks++;
      if (!ok || gid !== id || gresp !== eresp) begin
        errors++; $display("FAIL b2b_wr[%0d]: done=%0d bid=%0d bresp=%b want 1/%0d/%b", i, ok, gid, gresp, id, eresp);
      end
      checks++;
      if (regs !== model_flat()) begin
        errors++; $display("FAIL b2b_regs[%0d]: got %h want %h", i, regs, model_flat());
      end
      id = ID_W'($urandom());
      edata = err ? '0 : model[a / STRB_W];
      read_txn(id, a, $urandom_range(0, 3), gid, gdata, gresp, glast, ok);
      checks++;
      if (!ok || gid !== id || gresp !== eresp || glast !== 1'b1) begin
        errors++; $display("FAIL b2b_rd[%0d]: done=%0d rid=%0d rresp=%b rlast=%b want 1/%0d/%b/1",
          i, ok, gid, gresp, glast, id, eresp);
      end
      checks++;
      if (gdata !== edata) begin
        errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, gdata, edata);
      end
    end
  endtask

  initial begin
    bus_if.awvalid_i = 1'b0; bus_if.awid_i = '0; bus_if.awaddr_i = '0;
    bus_if.wvalid_i = 1'b0; bus_if.wdata_i = '0; bus_if.wstrb_i = '0; bus_if.wlast_i = 1'b1;
    bus_if.bready_i = 1'b0;
    bus_if.arvalid_i = 1'b0; bus_if.arid_i = '0; bus_if.araddr_i = '0;
    bus_if.rready_i = 1'b0;
    model_clear();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_errors();
    test_read_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
